// File: rtl/vid_meas_pkg.sv
// Shared types and constants for the video stream measurement block.
package vid_meas_pkg;

    // Receiver state: hunting for blanking after reset, waiting for a frame, inside a frame
    typedef enum logic [1:0] {
        S_SYNC,
        S_VBLANK,
        S_FRAME
    } state_t;

    // Bit positions inside the sticky error vector
    localparam int ERR_LINE_LEN = 0;
    localparam int ERR_DE_BLANK = 1;
    localparam int ERR_OVF      = 2;
    localparam int ERR_WIDTH    = 3;

    // Checksum accumulator width
    localparam int CSUM_WIDTH = 32;

endpackage

// File: rtl/vid_sync_edge.sv
// Registers hs/vs and derives the edges the frame checker acts on.
// Previous values reset to 1 so a stream starting in blanking or active
// does not produce a false rising edge on the first cycle.
module vid_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic hs,
    input  logic vs,
    output logic hs_rise,
    output logic vs_rise,
    output logic vs_fall
);

    logic [1:0] sig_now;
    logic [1:0] prev_reg;
    logic [1:0] rise;

    assign sig_now = {vs, hs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            // Hold last sampled level of each sync signal
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_reg[gi] <= 1'b1;
                end else begin
                    prev_reg[gi] <= sig_now[gi];
                end
            end

            assign rise[gi] = sig_now[gi] & ~prev_reg[gi];
        end
    endgenerate

    assign hs_rise = rise[0];
    assign vs_rise = rise[1];
    assign vs_fall = ~vs & prev_reg[1];

endmodule

// File: rtl/vid_stream_meas.sv
// Frame-level checker for a de/hs/vs pixel stream: measures width and
// height, accumulates a checksum, flags protocol errors and reports the
// results once per frame with a single-cycle frame_done_o pulse.
module vid_stream_meas
    import vid_meas_pkg::*;
#(
    parameter int PIXEL_WIDTH    = 10,
    parameter int LINE_SIZE_MAX  = 4096,
    parameter int FRAME_LINE_MAX = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [PIXEL_WIDTH*3-1:0]              di_i,
    input  logic                                  de_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    output logic [$clog2(LINE_SIZE_MAX+1)-1:0]    width_o,
    output logic [$clog2(FRAME_LINE_MAX+1)-1:0]   height_o,
    output logic [CSUM_WIDTH-1:0]                 csum_o,
    output logic [ERR_WIDTH-1:0]                  err_o,
    output logic [15:0]                           frame_cnt_o,
    output logic                                  frame_done_o
);

    localparam int WCNT = $clog2(LINE_SIZE_MAX + 1);
    localparam int HCNT = $clog2(FRAME_LINE_MAX + 1);
    localparam logic [WCNT-1:0] PIX_MAX  = WCNT'(LINE_SIZE_MAX);
    localparam logic [HCNT-1:0] LINE_MAX = HCNT'(FRAME_LINE_MAX);

    logic hs_rise;
    logic vs_rise;
    logic vs_fall;

    vid_sync_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs_i),
        .vs      (vs_i),
        .hs_rise (hs_rise),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    state_t                 state_reg;
    logic [WCNT-1:0]        pix_cnt_reg;
    logic [HCNT-1:0]        line_cnt_reg;
    logic [WCNT-1:0]        ref_w_reg;
    logic [CSUM_WIDTH-1:0]  csum_reg;
    logic [ERR_WIDTH-1:0]   err_reg;
    logic                   de_pend_reg;
    logic                   report_pend_reg;
    logic [WCNT-1:0]        width_reg;
    logic [HCNT-1:0]        height_reg;
    logic [CSUM_WIDTH-1:0]  csum_out_reg;
    logic [ERR_WIDTH-1:0]   err_out_reg;
    logic [15:0]            frame_cnt_reg;
    logic                   frame_done_reg;

    logic in_frame;
    logic pix_accept;
    logic de_blank;
    logic line_close;

    // Classify the current cycle inside a frame
    assign in_frame   = (state_reg == S_FRAME);
    assign pix_accept = in_frame && de_i && !hs_i && vs_i;
    assign de_blank   = in_frame && de_i && (hs_i || !vs_i);
    // A line closes once, whether by hs rising, vs falling, or both together
    assign line_close = in_frame && (pix_cnt_reg != '0) && (hs_rise || vs_fall);

    // Frame FSM, per-frame counters and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_SYNC;
            pix_cnt_reg     <= '0;
            line_cnt_reg    <= '0;
            ref_w_reg       <= '0;
            csum_reg        <= '0;
            err_reg         <= '0;
            de_pend_reg     <= 1'b0;
            report_pend_reg <= 1'b0;
            width_reg       <= '0;
            height_reg      <= '0;
            csum_out_reg    <= '0;
            err_out_reg     <= '0;
            frame_cnt_reg   <= '0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            // Publish the frame closed on the previous cycle
            if (report_pend_reg) begin
                width_reg       <= ref_w_reg;
                height_reg      <= line_cnt_reg;
                csum_out_reg    <= csum_reg;
                err_out_reg     <= err_reg;
                frame_cnt_reg   <= frame_cnt_reg + 16'd1;
                frame_done_reg  <= 1'b1;
                report_pend_reg <= 1'b0;
            end

            case (state_reg)
                S_SYNC: begin
                    if (!vs_i) begin
                        state_reg <= S_VBLANK;
                    end
                end

                S_VBLANK: begin
                    if (vs_rise) begin
                        pix_cnt_reg               <= '0;
                        line_cnt_reg              <= '0;
                        ref_w_reg                 <= '0;
                        csum_reg                  <= '0;
                        err_reg                   <= '0;
                        // de seen during blanking is charged to the frame that follows
                        err_reg[ERR_DE_BLANK]     <= de_pend_reg | de_i;
                        de_pend_reg               <= 1'b0;
                        state_reg                 <= S_FRAME;
                    end else if (de_i) begin
                        de_pend_reg <= 1'b1;
                    end
                end

                S_FRAME: begin
                    if (pix_accept) begin
                        csum_reg <= csum_reg + CSUM_WIDTH'(di_i);
                        if (pix_cnt_reg == PIX_MAX) begin
                            err_reg[ERR_OVF] <= 1'b1;
                        end else begin
                            pix_cnt_reg <= pix_cnt_reg + 1'b1;
                        end
                    end

                    if (de_blank) begin
                        err_reg[ERR_DE_BLANK] <= 1'b1;
                    end

                    if (line_close) begin
                        if (line_cnt_reg == LINE_MAX) begin
                            err_reg[ERR_OVF] <= 1'b1;
                        end else begin
                            line_cnt_reg <= line_cnt_reg + 1'b1;
                        end
                        // First counted line defines the reference width
                        if (line_cnt_reg == '0) begin
                            ref_w_reg <= pix_cnt_reg;
                        end else if (pix_cnt_reg != ref_w_reg) begin
                            err_reg[ERR_LINE_LEN] <= 1'b1;
                        end
                        pix_cnt_reg <= '0;
                    end

                    if (vs_fall) begin
                        report_pend_reg <= 1'b1;
                        state_reg       <= S_VBLANK;
                    end
                end

                default: begin
                    state_reg <= S_SYNC;
                end
            endcase
        end
    end

    assign width_o      = width_reg;
    assign height_o     = height_reg;
    assign csum_o       = csum_out_reg;
    assign err_o        = err_out_reg;
    assign frame_cnt_o  = frame_cnt_reg;
    assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_vid_stream_meas.sv
// Scoreboard bench for vid_stream_meas: the stimulus process builds whole
// frames from a list of line lengths, derives the expected report from
// those lengths and the pixel data, and queues it; a monitor pops and
// compares whenever frame_done_o pulses.
module tb_vid_stream_meas;

    localparam int PW = 10;
    localparam int DW = PW * 3;
    localparam int WC = $clog2(4096 + 1);
    localparam int HC = $clog2(4096 + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] di  = '0;
    logic          de  = 1'b0;
    logic          hs  = 1'b1;
    logic          vs  = 1'b0;

    logic [WC-1:0] width_o;
    logic [HC-1:0] height_o;
    logic [31:0]   csum_o;
    logic [2:0]    err_o;
    logic [15:0]   frame_cnt_o;
    logic          frame_done_o;

    vid_stream_meas #(
        .PIXEL_WIDTH    (PW),
        .LINE_SIZE_MAX  (4096),
        .FRAME_LINE_MAX (4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .di_i         (di),
        .de_i         (de),
        .hs_i         (hs),
        .vs_i         (vs),
        .width_o      (width_o),
        .height_o     (height_o),
        .csum_o       (csum_o),
        .err_o        (err_o),
        .frame_cnt_o  (frame_cnt_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         w;
        int         h;
        logic [31:0] csum;
        logic [2:0]  err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   line_len [0:127];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of stream; values are sampled at the next rising edge
    task automatic drive(input logic d_de, input logic d_hs, input logic d_vs, input logic [DW-1:0] d_di);
        de = d_de;
        hs = d_hs;
        vs = d_vs;
        di = d_di;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        de  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_width",     32'(width_o),     32'd0);
        check("rst_height",    32'(height_o),    32'd0);
        check("rst_csum",      csum_o,           32'd0);
        check("rst_err",       32'(err_o),       32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check("rst_done",      32'(frame_done_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Send a frame built from line_len[0..nl-1].
    // trail: last line ends with an hs rise; bad_line: line whose hblank
    // carries a stray de; rst_line: reset after that line (frame dropped).
    task automatic send_frame(input int nl, input int gap, input int hbl, input bit trail,
                              input int bad_line, input bit rnd, input int rst_line);
        exp_t          e;
        int            first;
        logic [DW-1:0] d;
        e.w    = 0;
        e.h    = 0;
        e.csum = '0;
        e.err  = '0;
        first  = -1;
        repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
        repeat (2) drive(1'b0, 1'b1, 1'b1, '0);
        for (int l = 0; l < nl; l++) begin
            if (line_len[l] == 0) drive(1'b0, 1'b0, 1'b1, '0);
            for (int p = 0; p < line_len[l]; p++) begin
                d = rnd ? DW'($urandom) : DW'(1);
                drive(1'b1, 1'b0, 1'b1, d);
                e.csum = e.csum + 32'(d);
                repeat (gap) drive(1'b0, 1'b0, 1'b1, '0);
            end
            if (line_len[l] > 0) begin
                if (first < 0) begin
                    first = line_len[l];
                    e.w   = first;
                end else if (line_len[l] != first) begin
                    e.err[0] = 1'b1;
                end
                e.h++;
            end
            if (l != nl - 1 || trail) begin
                for (int k = 0; k < hbl; k++) begin
                    if (l == bad_line && k == 1) begin
                        drive(1'b1, 1'b1, 1'b1, DW'($urandom) | DW'(1));
                        e.err[1] = 1'b1;
                    end else begin
                        drive(1'b0, 1'b1, 1'b1, '0);
                    end
                end
            end
            if (l == rst_line) do_reset();
        end
        drive(1'b0, trail, 1'b0, '0);
        if (rst_line < 0) begin
            sb.push_back(e);
            // The edge just passed sampled vs low; report appears on the next edge
            @(negedge clk);
            check("done_early", 32'(frame_done_o), 32'd0);
            @(negedge clk);
            check("done_latency", 32'(frame_done_o), 32'd1);
            @(negedge clk);
            check("done_pulse_len", 32'(frame_done_o), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare each reported frame against the head of the scoreboard
    initial begin : monitor
        exp_t        e;
        logic [15:0] exp_fc;
        exp_fc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_fc = '0;
            end else if (frame_done_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done got=frame_done exp=no_report");
                end else begin
                    e      = sb.pop_front();
                    exp_fc = exp_fc + 16'd1;
                    $display("frame %0d: w=%0d h=%0d csum=%08h err=%03b (exp w=%0d h=%0d csum=%08h err=%03b)",
                             frame_cnt_o, width_o, height_o, csum_o, err_o, e.w, e.h, e.csum, e.err);
                    check("width",     32'(width_o),     32'(e.w));
                    check("height",    32'(height_o),    32'(e.h));
                    check("csum",      csum_o,           e.csum);
                    check("err",       32'(err_o),       32'(e.err));
                    check("frame_cnt", 32'(frame_cnt_o), 32'(exp_fc));
                end
            end
        end
    end

    initial begin : watchdog
        #(10 * 200000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        int h;
        @(posedge clk);
        #1;
        do_reset();

        // 24x24, de every other clock, constant data, long hblank
        for (int l = 0; l < 24; l++) line_len[l] = 24;
        send_frame(24, 1, 35, 1'b1, -1, 1'b0, -1);

        // Two randomized frames with full-width random data
        repeat (2) begin
            w = $urandom_range(40, 120);
            h = $urandom_range(40, 100);
            for (int l = 0; l < h; l++) line_len[l] = w;
            send_frame(h, 0, 6, 1'b1, -1, 1'b1, -1);
        end

        // Short line 5 plus an empty line that must not be counted
        for (int l = 0; l < 17; l++) line_len[l] = 16;
        line_len[4] = 15;
        line_len[9] = 0;
        send_frame(17, 0, 4, 1'b1, -1, 1'b1, -1);

        // Stray de during hblank
        for (int l = 0; l < 16; l++) line_len[l] = 16;
        send_frame(16, 1, 4, 1'b1, 6, 1'b1, -1);

        // Reset mid-frame: that frame is dropped, the next one is reported
        send_frame(16, 0, 4, 1'b1, -1, 1'b1, 8);
        send_frame(16, 0, 4, 1'b1, -1, 1'b1, -1);

        // Last line closed by the vs fall itself
        send_frame(16, 0, 4, 1'b0, -1, 1'b1, -1);

        // vs pulse without any pixels
        send_frame(0, 0, 4, 1'b1, -1, 1'b0, -1);

        // Drain: every queued report must have been seen
        for (int i = 0; i < 20 && sb.size() != 0; i++) drive(1'b0, 1'b1, 1'b0, '0);
        repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
